// File: rtl/sn_pkg.sv
// Shared types and sizing helpers for the stochastic-number decode/encode slice.
// Optional build macro: SN_BIPOLAR_EN (adds one bit for the signed bipolar result).
package sn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } sn_dec_state_t;

    function automatic int sn_win_n(input int win_log2);
        return 1 << win_log2;
    endfunction

    // Count must reach N itself, so one bit more than log2(N).
    function automatic int sn_out_w(input int win_log2);
        return win_log2 + 1;
    endfunction

    localparam int SN_WIN_LOG2 = 4;
    localparam int SN_N        = sn_win_n(SN_WIN_LOG2);
    localparam int SN_OUT_W    = sn_out_w(SN_WIN_LOG2);

`ifdef SN_BIPOLAR_EN
    localparam int SN_BIP_EXTRA_W = 1;
`else
    localparam int SN_BIP_EXTRA_W = 0;
`endif

endpackage

// File: rtl/sn_window_counter.sv
// Window bit counter and ones counter; done stays high once N bits are in
// and further enables are ignored until the window is cleared.
module sn_window_counter
    import sn_pkg::*;
#(
    parameter int WIN_LOG2 = SN_WIN_LOG2,
    parameter int OUT_W    = WIN_LOG2 + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [OUT_W-1:0] ones_o,
    output logic             done_o
);

    localparam int N = sn_win_n(WIN_LOG2);

    logic [OUT_W-1:0] bit_cnt_q;
    logic [OUT_W-1:0] bit_cnt_d;
    logic [OUT_W-1:0] ones_q;
    logic [OUT_W-1:0] ones_d;
    logic             full;

    assign full = (bit_cnt_q == OUT_W'(N));

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        ones_d    = ones_q;
        if (clr_i) begin
            bit_cnt_d = '0;
            ones_d    = '0;
        end else if (en_i && !full) begin
            bit_cnt_d = bit_cnt_q + OUT_W'(1);
            ones_d    = ones_q + OUT_W'(bit_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            ones_q    <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            ones_q    <= ones_d;
        end
    end

    assign ones_o = ones_q;
    assign done_o = full;

endmodule

// File: rtl/sn_stream_decoder.sv
// Unipolar SN bitstream to binary: counts ones over N accepted bits and offers the
// count on a valid/ready handshake. Optional build macro: SN_BIPOLAR_EN (prob_bip).
module sn_stream_decoder
    import sn_pkg::*;
#(
    parameter int WIN_LOG2 = SN_WIN_LOG2,
    parameter int OUT_W    = WIN_LOG2 + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             sn_bit,
    input  logic             sn_valid,
    output logic [OUT_W-1:0] prob,
    output logic             prob_valid,
    input  logic             prob_ready,
    output logic             busy,
    output logic             overrun
`ifdef SN_BIPOLAR_EN
    ,
    output logic signed [OUT_W+SN_BIP_EXTRA_W-1:0] prob_bip
`endif
);

    localparam int N = sn_win_n(WIN_LOG2);

`ifdef SN_BIPOLAR_EN
    localparam int BIP_W = OUT_W + SN_BIP_EXTRA_W;
    localparam logic signed [BIP_W-1:0] BIP_RST = BIP_W'(-N);

    // 2*ones - N; the intermediate carries one spare bit so 2*N cannot wrap.
    function automatic logic signed [BIP_W-1:0] to_bipolar(input logic [OUT_W-1:0] ones_in);
        logic signed [OUT_W+1:0] wide;
        wide = $signed({1'b0, ones_in, 1'b0}) - $signed((OUT_W + 2)'(N));
        return $signed(wide[BIP_W-1:0]);
    endfunction

    logic signed [BIP_W-1:0] prob_bip_q;
`endif

    sn_dec_state_t    state_q;
    logic [OUT_W-1:0] prob_q;
    logic             prob_valid_q;
    logic             busy_q;
    logic             overrun_q;

    logic [OUT_W-1:0] ones;
    logic             win_done;
    logic             hs;
    logic             cnt_clr;
    logic             cnt_en;
    logic             ovr_set;
    logic             ovr_clr;

    assign hs      = prob_valid_q & prob_ready;
    // Counters sit cleared outside ACCUM so every window entry starts from zero.
    assign cnt_clr = (state_q != ACCUM) | start;
    assign cnt_en  = (state_q == ACCUM) & sn_valid & ~start;
    assign ovr_set = sn_valid & (state_q != ACCUM);
    assign ovr_clr = start & ((state_q != HOLD) | hs);

    sn_window_counter #(
        .WIN_LOG2 (WIN_LOG2),
        .OUT_W    (OUT_W)
    ) u_win (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .bit_i  (sn_bit),
        .ones_o (ones),
        .done_o (win_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            prob_q       <= '0;
            prob_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SN_BIPOLAR_EN
            prob_bip_q   <= BIP_RST;
`endif
        end else begin
            if (ovr_clr) begin
                overrun_q <= 1'b0;
            end else if (ovr_set) begin
                overrun_q <= 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ACCUM;
                        busy_q  <= 1'b1;
                    end
                end
                ACCUM: begin
                    // A restart outranks a window that has just filled.
                    if (!start && win_done) begin
                        state_q      <= HOLD;
                        busy_q       <= 1'b0;
                        prob_q       <= ones;
                        prob_valid_q <= 1'b1;
`ifdef SN_BIPOLAR_EN
                        prob_bip_q   <= to_bipolar(ones);
`endif
                    end
                end
                HOLD: begin
                    if (hs) begin
                        prob_valid_q <= 1'b0;
                        if (cont || start) begin
                            state_q <= ACCUM;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    prob_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign prob       = prob_q;
    assign prob_valid = prob_valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
`ifdef SN_BIPOLAR_EN
    assign prob_bip   = prob_bip_q;
`endif

endmodule

// File: doc/sn_stream_decoder.md
Name: sn_stream_decoder

Overview:
- Receive end of the stochastic-number (SN) datapath: takes a serial unipolar SN bitstream with per-bit valid and converts it back to binary.
- Counts ones over a fixed window of N = 2**WIN_LOG2 accepted bits and presents the count with a valid/ready handshake.
- Sits downstream of the LFSR/comparator SN generators and multipliers, or of SN bits arriving on uio_in.
- Count width holds the full range 0..N, so an all-ones window never wraps.

Parameters:
- WIN_LOG2, 4, log2 of the window length N; legal range 2..8.
- OUT_W, WIN_LOG2+1, width of the ones count; must stay WIN_LOG2+1.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; synchronous, active-low
- start  input  1  one-cycle pulse; begin a new window and clear overrun
- cont  input  1  continuous mode; sampled when the prob handshake completes
- sn_bit  input  1  stochastic bit
- sn_valid  input  1  sn_bit is valid this cycle
- prob  output  OUT_W  ones count of the last completed window
- prob_valid  output  1  prob is valid and held until accepted
- prob_ready  input  1  consumer accepts prob
- busy  output  1  high in ACCUM
- overrun  output  1  sticky; an sn_valid bit was dropped outside ACCUM

Behaviour:
- One clock. Reset is synchronous and active-low; clock and reset ports are clk and rst_n.
- Reset (rst_n=0 at a clk edge) sets: state IDLE, prob=0, prob_valid=0, busy=0, overrun=0, internal counters 0. Reset has priority over every other input and aborts a window mid-operation; no partial result is emitted.
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - start=1 -> ACCUM; bit_cnt=0, ones=0, overrun=0.
  - sn_valid=1 without start -> bit dropped, overrun set.
- ACCUM:
  - Each cycle with sn_valid=1: bit_cnt+=1 and ones+=sn_bit.
  - The bit accepted with bit_cnt==N-1 completes the window. Next cycle: prob = final ones (including this bit), prob_valid=1, state HOLD.
  - Latency: last bit accepted at edge k -> prob_valid high after edge k+1.
  - sn_valid=0 cycles are stalls; the window spans exactly N accepted bits.
  - start=1 in ACCUM restarts the window (counters cleared). The bit presented in that cycle is not counted.
- HOLD:
  - prob and prob_valid are stable until prob_valid & prob_ready.
  - On handshake with cont=1 -> ACCUM with cleared counters. The first bit can be accepted the cycle after the handshake.
  - On handshake with cont=0 -> IDLE.
  - sn_valid=1 in HOLD -> bit dropped, overrun set. This includes the handshake cycle.
  - start=1 in HOLD without handshake is ignored; start with handshake behaves as cont=1 and clears overrun.
- Simultaneous start and overrun-set event: the clear wins.
- After a handshake prob keeps its last value; prob_valid drops.
- Arithmetic: ones and bit_cnt are unsigned OUT_W bits. ones max = N (all ones), e.g. N=16 -> prob=5'd16. No saturation is needed.

Optional Feature:
- Macro SN_BIPOLAR_EN.
- When defined:
  - Extra output prob_bip, signed OUT_W+1 bits, equal to 2*ones - N (range -N..+N).
  - Registered and valid together with prob under the same handshake.
  - Reset value is -N (all-zero window).
- When undefined: the port and its logic are absent; prob behaviour is unchanged.

Decomposition:
- Package sn_pkg holds:
  - enum sn_dec_state_t {IDLE, ACCUM, HOLD}
  - localparam helpers for N and OUT_W
  - SN_BIPOLAR_EN-dependent width constant
- Sub-module sn_window_counter: bit_cnt and ones counters with clear, enable, and window-done output. It is shared with the future windowed SN encoder; the FSM and handshake stay in the top.

Test Plan:
- WIN_LOG2=4, start, 16 valid bits all 1 -> prob=16, prob_valid one cycle after the 16th bit; prob_bip=+16 if SN_BIPOLAR_EN.
- 16 bits alternating 1,0 with random sn_valid gaps, prob_ready=1, cont=0 -> prob=8, prob_bip=0, state returns to IDLE, busy=0.
- Window complete with prob_ready held low 5 cycles while sn_valid=1 -> prob and prob_valid stable, overrun=1. Next, ready=1 with cont=1 -> new window counts only bits after the handshake.
- cont=1 back-to-back windows of 0s then 1s -> prob sequence 0, 16, with one-cycle gap between windows.
- rst_n=0 after 9 of 16 bits -> all outputs 0 next cycle, no prob_valid. A following start plus 16 zeros -> prob=0.
- start pulsed after 7 bits in ACCUM -> counters restart; result reflects only the following 16 accepted bits. overrun cleared by start.
